// File: rtl/alu_exec_sequencer_pkg.sv
// alu_exec_sequencer_pkg
// Shared definitions for the ALU execute-stage sequencer:
//   - ALU opcode constants (3-bit) and request function codes (4-bit)
//   - FSM state encoding
//   - decoded-function record produced by alu_func_decode
//   - default datapath width
package alu_exec_sequencer_pkg;

  localparam int W_DEF = 24;

  // ALU opcodes
  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_MAX   = 3'd3;
  localparam logic [2:0] OP_CMP   = 3'd4;
  localparam logic [2:0] OP_EQUAL = 3'd5;
  localparam logic [2:0] OP_SUBSF = 3'd6;

  // Request function codes (7 and 12..15 are illegal)
  localparam logic [3:0] F_ADD  = 4'd0;
  localparam logic [3:0] F_SUB  = 4'd1;
  localparam logic [3:0] F_AND  = 4'd2;
  localparam logic [3:0] F_MAX  = 4'd3;
  localparam logic [3:0] F_SUBS = 4'd4;
  localparam logic [3:0] F_SEQ  = 4'd5;
  localparam logic [3:0] F_SLE  = 4'd6;
  localparam logic [3:0] F_BEQ  = 4'd8;
  localparam logic [3:0] F_BNE  = 4'd9;
  localparam logic [3:0] F_BLE  = 4'd10;
  localparam logic [3:0] F_BGT  = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Where rsp_result comes from
  typedef enum logic [1:0] {
    RES_NONE = 2'd0,  // constant 0 (branches)
    RES_ALU  = 2'd1,  // alu_result
    RES_FLAG = 2'd2   // zero-extended alu_zero (SEQ/SLE)
  } res_src_e;

  typedef struct packed {
    logic [2:0] opcode;
    logic       is_branch;
    logic       br_inv;      // taken = alu_zero ^ br_inv
    logic       zero_local;  // rsp_zero from (alu_result == 0) instead of alu_zero
    res_src_e   res_src;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/alu_exec_sequencer_if.sv
// alu_exec_sequencer_if
// Request, ALU and response signals of the execute-stage sequencer.
//   master: the sequencer (drives req_ready, alu_a/alu_b/alu_opcode, rsp_*)
//   slave : the environment (issue stage, combinational ALU, writeback)
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; a producer holding valid keeps its payload stable until
// that edge, and valid never depends combinationally on ready.
interface alu_exec_sequencer_if #(parameter int W = 24);
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_func;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [W-1:0] req_pc;
  logic [W-1:0] req_off;

  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_opcode;
  logic [W-1:0] alu_result;
  logic         alu_zero;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_zero;
  logic         rsp_taken;
  logic [W-1:0] rsp_target;
  logic         rsp_illegal;

  modport master (
    input  req_valid, req_func, req_a, req_b, req_pc, req_off,
    input  alu_result, alu_zero, rsp_ready,
    output req_ready, alu_a, alu_b, alu_opcode,
    output rsp_valid, rsp_result, rsp_zero, rsp_taken, rsp_target, rsp_illegal
  );

  modport slave (
    output req_valid, req_func, req_a, req_b, req_pc, req_off,
    output alu_result, alu_zero, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_opcode,
    input  rsp_valid, rsp_result, rsp_zero, rsp_taken, rsp_target, rsp_illegal
  );
endinterface

// File: rtl/alu_exec_sequencer_func_decode.sv
// alu_func_decode
// Combinational map from request function code to ALU opcode and the
// response-capture controls.
//   func_i : 4-bit request function code
//   dec_o  : opcode, branch flags, flag/result source, illegal
module alu_func_decode
  import alu_exec_sequencer_pkg::*;
(
  input  logic [3:0] func_i,
  output dec_t       dec_o
);
  always_comb begin
    dec_o         = '0;
    dec_o.res_src = RES_NONE;
    case (func_i)
      F_ADD:  begin dec_o.opcode = OP_ADD;   dec_o.zero_local = 1'b1; dec_o.res_src = RES_ALU; end
      F_SUB:  begin dec_o.opcode = OP_SUB;   dec_o.zero_local = 1'b1; dec_o.res_src = RES_ALU; end
      F_AND:  begin dec_o.opcode = OP_AND;   dec_o.zero_local = 1'b1; dec_o.res_src = RES_ALU; end
      F_MAX:  begin dec_o.opcode = OP_MAX;   dec_o.zero_local = 1'b1; dec_o.res_src = RES_ALU; end
      F_SUBS: begin dec_o.opcode = OP_SUBSF; dec_o.res_src = RES_ALU;  end
      F_SEQ:  begin dec_o.opcode = OP_EQUAL; dec_o.res_src = RES_FLAG; end
      F_SLE:  begin dec_o.opcode = OP_CMP;   dec_o.res_src = RES_FLAG; end
      F_BEQ:  begin dec_o.opcode = OP_EQUAL; dec_o.is_branch = 1'b1; end
      F_BNE:  begin dec_o.opcode = OP_EQUAL; dec_o.is_branch = 1'b1; dec_o.br_inv = 1'b1; end
      F_BLE:  begin dec_o.opcode = OP_CMP;   dec_o.is_branch = 1'b1; end
      F_BGT:  begin dec_o.opcode = OP_CMP;   dec_o.is_branch = 1'b1; dec_o.br_inv = 1'b1; end
      default: dec_o.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_exec_sequencer.sv
// alu_exec_sequencer
// Multicycle execute-stage controller: accepts a decoded request, drives a
// combinational ALU with registered operands for ALU_LAT cycles, samples
// result/zero and returns a registered response with branch decision/target.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus          : request / ALU / response signals (master side)
//   dbg_state_o  : current FSM state
//   stat_ops, stat_taken : response counters, present only when the
//                  ALU_EXEC_STATS_EN macro is defined
module alu_exec_sequencer
  import alu_exec_sequencer_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int ALU_LAT = 1       // 1..7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_exec_sequencer_if.master  bus,
  output state_e                dbg_state_o
`ifdef ALU_EXEC_STATS_EN
  , output logic [15:0]         stat_ops
  , output logic [15:0]         stat_taken
`endif
);
  state_e       state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]   alu_op_q, alu_op_d;
  logic         br_q, br_d, inv_q, inv_d, zloc_q, zloc_d;
  res_src_e     res_src_q, res_src_d;
  logic [W-1:0] tgt_q, tgt_d;
  logic [W-1:0] rsp_result_q, rsp_result_d, rsp_target_q, rsp_target_d;
  logic         rsp_zero_q, rsp_zero_d, rsp_taken_q, rsp_taken_d;
  logic         rsp_illegal_q, rsp_illegal_d;
  dec_t         dec_req;

  alu_func_decode u_dec (.func_i(bus.req_func), .dec_o(dec_req));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      br_q          <= 1'b0;
      inv_q         <= 1'b0;
      zloc_q        <= 1'b0;
      res_src_q     <= RES_NONE;
      tgt_q         <= '0;
      rsp_result_q  <= '0;
      rsp_target_q  <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_taken_q   <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      br_q          <= br_d;
      inv_q         <= inv_d;
      zloc_q        <= zloc_d;
      res_src_q     <= res_src_d;
      tgt_q         <= tgt_d;
      rsp_result_q  <= rsp_result_d;
      rsp_target_q  <= rsp_target_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_taken_q   <= rsp_taken_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    br_d          = br_q;
    inv_d         = inv_q;
    zloc_d        = zloc_q;
    res_src_d     = res_src_q;
    tgt_d         = tgt_q;
    rsp_result_d  = rsp_result_q;
    rsp_target_d  = rsp_target_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_taken_d   = rsp_taken_q;
    rsp_illegal_d = rsp_illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (dec_req.illegal) begin
            // No ALU work: alu_* keep their previous values
            rsp_illegal_d = 1'b1;
            rsp_result_d  = '0;
            rsp_zero_d    = 1'b0;
            rsp_taken_d   = 1'b0;
            rsp_target_d  = '0;
            state_d       = ST_RESP;
          end else begin
            alu_a_d   = bus.req_a;
            alu_b_d   = bus.req_b;
            alu_op_d  = dec_req.opcode;
            br_d      = dec_req.is_branch;
            inv_d     = dec_req.br_inv;
            zloc_d    = dec_req.zero_local;
            res_src_d = dec_req.res_src;
            // Target only depends on pc/off, so it is formed at accept time
            tgt_d     = dec_req.is_branch ? (bus.req_pc + W'(1) + bus.req_off) : '0;
            cnt_d     = 3'(ALU_LAT);
            state_d   = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          case (res_src_q)
            RES_ALU:  rsp_result_d = bus.alu_result;
            RES_FLAG: rsp_result_d = {{(W-1){1'b0}}, bus.alu_zero};
            default:  rsp_result_d = '0;
          endcase
          // The ALU leaves its zero flag stale for ADD/SUB/AND/MAX
          rsp_zero_d    = zloc_q ? (bus.alu_result == '0) : bus.alu_zero;
          rsp_taken_d   = br_q & (bus.alu_zero ^ inv_q);
          rsp_target_d  = tgt_q;
          rsp_illegal_d = 1'b0;
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.req_ready   = (state_q == ST_IDLE);
  assign bus.rsp_valid   = (state_q == ST_RESP);
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_opcode  = alu_op_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_zero    = rsp_zero_q;
  assign bus.rsp_taken   = rsp_taken_q;
  assign bus.rsp_target  = rsp_target_q;
  assign bus.rsp_illegal = rsp_illegal_q;
  assign dbg_state_o     = state_q;

`ifdef ALU_EXEC_STATS_EN
  logic [15:0] ops_q, taken_q;
  logic        rsp_hs;
  assign rsp_hs = (state_q == ST_RESP) && bus.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_q   <= '0;
      taken_q <= '0;
    end else if (rsp_hs) begin
      if (!rsp_illegal_q) ops_q   <= ops_q + 16'd1;
      if (rsp_taken_q)    taken_q <= taken_q + 16'd1;
    end
  end

  assign stat_ops   = ops_q;
  assign stat_taken = taken_q;
`endif
endmodule

// File: tb/tb_alu_exec_sequencer.sv
// tb_alu_exec_sequencer
// Two sequencers (ALU_LAT=1 and ALU_LAT=4) share one set of request
// stimulus; sel routes req_valid to one of them and picks which outputs are
// observed. Each has its own behavioural ALU that leaves unspecified fields
// at random junk values. Optional counters: ALU_EXEC_STATS_EN.
module tb_alu_exec_sequencer;
  import alu_exec_sequencer_pkg::*;

  typedef struct packed {
    logic [23:0] result;
    logic        zero;
    logic        taken;
    logic [23:0] target;
    logic        illegal;
    logic [2:0]  opcode;
  } exp_t;

  logic clk, rst_n;
  logic sel, rv, rr;
  logic [3:0]  req_func;
  logic [23:0] req_a, req_b, req_pc, req_off;
  logic [23:0] junk_res;
  logic        junk_zero;
  int checks, failures;
  logic [23:0] exp_q[$];
  logic [23:0] exp_a[2], exp_b[2];
  logic [2:0]  exp_op[2];
  logic [15:0] exp_ops[2], exp_tk[2];

  alu_exec_sequencer_if #(.W(24)) if1 ();
  alu_exec_sequencer_if #(.W(24)) if4 ();
  state_e st1, st4;

`ifdef ALU_EXEC_STATS_EN
  logic [15:0] ops1, tk1, ops4, tk4;
`endif

  alu_exec_sequencer #(.W(24), .ALU_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.master), .dbg_state_o(st1)
`ifdef ALU_EXEC_STATS_EN
    , .stat_ops(ops1), .stat_taken(tk1)
`endif
  );
  alu_exec_sequencer #(.W(24), .ALU_LAT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4.master), .dbg_state_o(st4)
`ifdef ALU_EXEC_STATS_EN
    , .stat_ops(ops4), .stat_taken(tk4)
`endif
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural ALU: fields an opcode does not update show junk
  function automatic logic [24:0] alu_fn(input logic [2:0] op, input logic [23:0] a, b,
                                         input logic [23:0] jr, input logic jz);
    logic [23:0] r;
    logic z;
    r = jr;
    z = jz;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = (a > b) ? a : b;
      3'd4: z = (a <= b);
      3'd5: z = (a == b);
      3'd6: begin r = a - b; z = (a == b); end
      default: ;
    endcase
    return {r, z};
  endfunction

  assign {if1.alu_result, if1.alu_zero} = alu_fn(if1.alu_opcode, if1.alu_a, if1.alu_b, junk_res, junk_zero);
  assign {if4.alu_result, if4.alu_zero} = alu_fn(if4.alu_opcode, if4.alu_a, if4.alu_b, junk_res, junk_zero);

  assign if1.req_valid = rv & ~sel;
  assign if4.req_valid = rv & sel;
  assign if1.req_func = req_func;  assign if4.req_func = req_func;
  assign if1.req_a    = req_a;     assign if4.req_a    = req_a;
  assign if1.req_b    = req_b;     assign if4.req_b    = req_b;
  assign if1.req_pc   = req_pc;    assign if4.req_pc   = req_pc;
  assign if1.req_off  = req_off;   assign if4.req_off  = req_off;
  assign if1.rsp_ready = rr;       assign if4.rsp_ready = rr;

  // Observed side, selected by sel
  logic        o_req_ready, o_rsp_valid, o_zero, o_taken, o_illegal;
  logic [23:0] o_alu_a, o_alu_b, o_result, o_target;
  logic [2:0]  o_op;
  logic [1:0]  o_state;
  assign o_req_ready = sel ? if4.req_ready   : if1.req_ready;
  assign o_rsp_valid = sel ? if4.rsp_valid   : if1.rsp_valid;
  assign o_zero      = sel ? if4.rsp_zero    : if1.rsp_zero;
  assign o_taken     = sel ? if4.rsp_taken   : if1.rsp_taken;
  assign o_illegal   = sel ? if4.rsp_illegal : if1.rsp_illegal;
  assign o_alu_a     = sel ? if4.alu_a       : if1.alu_a;
  assign o_alu_b     = sel ? if4.alu_b       : if1.alu_b;
  assign o_result    = sel ? if4.rsp_result  : if1.rsp_result;
  assign o_target    = sel ? if4.rsp_target  : if1.rsp_target;
  assign o_op        = sel ? if4.alu_opcode  : if1.alu_opcode;
  assign o_state     = sel ? st4             : st1;

  // Reference model, straight from the function table
  function automatic exp_t ref_model(input logic [3:0] f, input logic [23:0] a, b, pc, off);
    exp_t e;
    logic le, eq;
    e  = '0;
    le = (a <= b);
    eq = (a == b);
    case (f)
      4'd0:  begin e.opcode = 3'd0; e.result = a + b; e.zero = (a + b == 24'd0); end
      4'd1:  begin e.opcode = 3'd1; e.result = a - b; e.zero = eq; end
      4'd2:  begin e.opcode = 3'd2; e.result = a & b; e.zero = ((a & b) == 24'd0); end
      4'd3:  begin e.opcode = 3'd3; e.result = (a > b) ? a : b; e.zero = (((a > b) ? a : b) == 24'd0); end
      4'd4:  begin e.opcode = 3'd6; e.result = a - b; e.zero = eq; end
      4'd5:  begin e.opcode = 3'd5; e.result = {23'd0, eq}; e.zero = eq; end
      4'd6:  begin e.opcode = 3'd4; e.result = {23'd0, le}; e.zero = le; end
      4'd8:  begin e.opcode = 3'd5; e.zero = eq; e.taken = eq;  e.target = pc + 24'd1 + off; end
      4'd9:  begin e.opcode = 3'd5; e.zero = eq; e.taken = !eq; e.target = pc + 24'd1 + off; end
      4'd10: begin e.opcode = 3'd4; e.zero = le; e.taken = le;  e.target = pc + 24'd1 + off; end
      4'd11: begin e.opcode = 3'd4; e.zero = le; e.taken = !le; e.target = pc + 24'd1 + off; end
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_expect();
    for (int i = 0; i < 2; i++) begin
      exp_a[i] = '0; exp_b[i] = '0; exp_op[i] = '0; exp_ops[i] = '0; exp_tk[i] = '0;
    end
  endtask

  // One full transaction on the selected sequencer; hold = cycles of
  // rsp_ready low, poke = drive a competing request while blocked
  task automatic do_op(input logic s, input logic [3:0] f, input logic [23:0] a, b, pc, off,
                       input int hold, input logic poke);
    exp_t e;
    logic [23:0] exp_res;
    int n;
    int lat_edges;
    e = ref_model(f, a, b, pc, off);
    exp_q.push_back(e.result);
    sel = s; junk_res = 24'($urandom); junk_zero = 1'($urandom);
    req_func = f; req_a = a; req_b = b; req_pc = pc; req_off = off; rv = 1'b1;
    check("req_ready_idle", 32'(o_req_ready), 32'd1);
    @(posedge clk); #1;
    rv = 1'b0;
    lat_edges = e.illegal ? 1 : (s ? 5 : 2);
    n = 1;
    while (!o_rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("rsp_latency", 32'(n), 32'(lat_edges));
    if (!e.illegal) begin
      exp_a[s] = a; exp_b[s] = b; exp_op[s] = e.opcode;
    end
    exp_res = exp_q.pop_front();
    check("alu_a", 32'(o_alu_a), 32'(exp_a[s]));
    check("alu_b", 32'(o_alu_b), 32'(exp_b[s]));
    check("alu_opcode", 32'(o_op), 32'(exp_op[s]));
    check("rsp_result", 32'(o_result), 32'(exp_res));
    check("rsp_zero", 32'(o_zero), 32'(e.zero));
    check("rsp_taken", 32'(o_taken), 32'(e.taken));
    check("rsp_target", 32'(o_target), 32'(e.target));
    check("rsp_illegal", 32'(o_illegal), 32'(e.illegal));
    rr = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        rv = 1'b1; req_func = 4'd0; req_a = 24'($urandom); req_b = 24'($urandom);
      end
      @(posedge clk); #1;
      check("hold_valid", 32'(o_rsp_valid), 32'd1);
      check("hold_req_ready", 32'(o_req_ready), 32'd0);
      check("hold_result", 32'(o_result), 32'(exp_res));
      check("hold_taken", 32'(o_taken), 32'(e.taken));
      check("hold_alu_a", 32'(o_alu_a), 32'(exp_a[s]));
    end
    rv = 1'b0; rr = 1'b1;
    @(posedge clk); #1;
    rr = 1'b0;
    if (!e.illegal) exp_ops[s] = exp_ops[s] + 16'd1;
    if (e.taken)    exp_tk[s]  = exp_tk[s] + 16'd1;
    check("after_hs_valid", 32'(o_rsp_valid), 32'd0);
    check("after_hs_ready", 32'(o_req_ready), 32'd1);
`ifdef ALU_EXEC_STATS_EN
    check("stat_ops", 32'(s ? ops4 : ops1), 32'(exp_ops[s]));
    check("stat_taken", 32'(s ? tk4 : tk1), 32'(exp_tk[s]));
`endif
  endtask

  initial begin
    logic [23:0] a, b;
    int seen;
    checks = 0; failures = 0;
    sel = 1'b0; rv = 1'b0; rr = 1'b0;
    req_func = '0; req_a = '0; req_b = '0; req_pc = '0; req_off = '0;
    junk_res = '0; junk_zero = 1'b0;
    clear_expect();
    rst_n = 1'b0;
    #12;
    // Reset state of both instances
    for (int k = 0; k < 2; k++) begin
      sel = k[0];
      #1;
      check("rst_state", 32'(o_state), 32'd0);
      check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
      check("rst_alu_a", 32'(o_alu_a), 32'd0);
      check("rst_alu_op", 32'(o_op), 32'd0);
      check("rst_result", 32'(o_result), 32'd0);
      check("rst_illegal", 32'(o_illegal), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    do_op(1'b0, 4'd0,  24'h000005, 24'hFFFFFB, 24'h0, 24'h0, 0, 1'b0);          // ADD -> 0
    do_op(1'b0, 4'd8,  24'h123456, 24'h123456, 24'h000010, 24'hFFFFF0, 0, 1'b0); // BEQ
    do_op(1'b0, 4'd9,  24'h123456, 24'h123456, 24'h000010, 24'hFFFFF0, 0, 1'b0); // BNE
    do_op(1'b0, 4'd11, 24'd7, 24'd3, 24'h000100, 24'h000004, 0, 1'b0);           // BGT
    do_op(1'b0, 4'd10, 24'd7, 24'd3, 24'h000100, 24'h000004, 0, 1'b0);           // BLE
    do_op(1'b0, 4'd13, 24'hABCDEF, 24'h111111, 24'h0, 24'h0, 0, 1'b0);           // illegal
    do_op(1'b0, 4'd7,  24'h1, 24'h2, 24'h0, 24'h0, 1, 1'b0);                     // illegal
    do_op(1'b0, 4'd3,  24'h800000, 24'h7FFFFF, 24'h0, 24'h0, 5, 1'b1);           // MAX, backpressure
    do_op(1'b0, 4'd5,  24'h42, 24'h42, 24'h0, 24'h0, 0, 1'b0);                   // SEQ right after
    do_op(1'b1, 4'd4,  24'h000010, 24'h000010, 24'h0, 24'h0, 2, 1'b1);           // SUBS, LAT=4
    do_op(1'b1, 4'd6,  24'hFFFFFF, 24'h000001, 24'h0, 24'h0, 0, 1'b0);           // SLE false
    do_op(1'b1, 4'd8,  24'h5, 24'h5, 24'hFFFFFF, 24'h000000, 0, 1'b0);           // target wraps to 0

    // Reset asserted while the LAT=4 instance is waiting on the ALU
    sel = 1'b1; req_func = 4'd1; req_a = 24'h9; req_b = 24'h2; rv = 1'b1;
    @(posedge clk); #1;
    rv = 1'b0;
    @(posedge clk); #1;
    check("wait_state", 32'(o_state), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_state", 32'(o_state), 32'd0);
    check("mid_rst_valid", 32'(o_rsp_valid), 32'd0);
    check("mid_rst_alu_a", 32'(o_alu_a), 32'd0);
    check("mid_rst_alu_b", 32'(o_alu_b), 32'd0);
    check("mid_rst_alu_op", 32'(o_op), 32'd0);
    check("mid_rst_result", 32'(o_result), 32'd0);
    check("mid_rst_zero", 32'(o_zero), 32'd0);
    check("mid_rst_taken", 32'(o_taken), 32'd0);
    check("mid_rst_target", 32'(o_target), 32'd0);
`ifdef ALU_EXEC_STATS_EN
    check("mid_rst_stat_ops", 32'(ops4), 32'd0);
    check("mid_rst_stat_taken", 32'(tk4), 32'd0);
`endif
    clear_expect();
    #3 rst_n = 1'b1;
    rr = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (o_rsp_valid) seen++;
    end
    rr = 1'b0;
    check("no_rsp_after_rst", 32'(seen), 32'd0);

    // Randomized traffic on both instances
    for (int i = 0; i < 30; i++) begin
      a = 24'($urandom);
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a + 24'($urandom_range(0, 2)) - 24'd1;
        2: b = 24'($urandom_range(0, 7));
        default: b = 24'($urandom);
      endcase
      do_op(1'($urandom), 4'($urandom_range(0, 15)), a, b, 24'($urandom), 24'($urandom),
            $urandom_range(0, 2), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_exec_sequencer.md
Name: alu_exec_sequencer

Overview:
- Multicycle execute-stage controller; the issuing side of the 24-bit ALU interface.
- Accepts decoded requests (function, operands, PC, branch offset) over valid/ready.
- Drives the combinational ALU's A/B/opcode inputs, holds them stable for ALU_LAT cycles, then samples result/zero.
- Returns a registered response: result, zero flag and branch decision/target, to the writeback/PC-select logic.

Parameters:
- W, 24, datapath width of operands, result, PC and target.
- ALU_LAT, 1, cycles the ALU inputs are held before sampling; legal range 1..7.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept; high only in IDLE.
- req_func  in  4  operation code, see Behaviour.
- req_a  in  W  operand A.
- req_b  in  W  operand B.
- req_pc  in  W  PC of the instruction.
- req_off  in  W  signed branch offset.
- alu_a  out  W  registered ALU operand A.
- alu_b  out  W  registered ALU operand B.
- alu_opcode  out  3  registered ALU opcode: 0 ADD, 1 SUB, 2 AND, 3 MAX, 4 CMP, 5 EQUAL, 6 SUBSF.
- alu_result  in  W  ALU result.
- alu_zero  in  1  ALU zero flag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  W  captured result.
- rsp_zero  out  1  zero flag.
- rsp_taken  out  1  branch taken.
- rsp_target  out  W  branch target.
- rsp_illegal  out  1  unsupported req_func.

Behaviour:
- Reset (async, any state): FSM to IDLE; every output and internal register is 0; alu_opcode=0; wait counter=0. An in-flight operation is discarded and no response is produced.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid at a clock edge:
  - Register alu_a, alu_b and alu_opcode, latch func/pc/off, load counter=ALU_LAT, go to WAIT.
  - If func is illegal: do not change alu_* registers, load rsp_illegal=1 and rsp_result=0, go directly to RESP.
- WAIT: counter decrements each edge. At the edge where counter==1, capture the response fields and go to RESP.
  - With ALU_LAT=1, rsp_valid rises 2 edges after the accept edge.
- RESP: rsp_valid=1, all rsp_* held stable until rsp_valid & rsp_ready at an edge. That edge clears rsp_valid and returns to IDLE.
  - req_ready stays 0 throughout, so requests never overlap. Minimum spacing is ALU_LAT+2 cycles.
- alu_* outputs keep their last values after completion.
- Function map (req_func -> ALU opcode; fields captured):
  - 0 ADD -> 0, 1 SUB -> 1, 2 AND -> 2, 3 MAX -> 3: rsp_result=alu_result; rsp_zero=(alu_result==0), computed locally because the ALU zero flag is not updated for these opcodes.
  - 4 SUBS -> 6: rsp_result=alu_result, rsp_zero=alu_zero.
  - 5 SEQ -> 5 and 6 SLE -> 4: rsp_result={0..,alu_zero}, rsp_zero=alu_zero. The ALU result is not updated for these opcodes and is never sampled.
  - 8 BEQ -> 5, taken=alu_zero. 9 BNE -> 5, taken=!alu_zero. 10 BLE -> 4, taken=alu_zero. 11 BGT -> 4, taken=!alu_zero.
  - For branches: rsp_result=0, rsp_zero=alu_zero.
  - rsp_target = req_pc+1+req_off, mod 2^W, wraps silently. Computed for branches only, otherwise 0.
  - rsp_taken=0 for all non-branch functions.
  - Codes 7 and 12..15 are illegal.
- All compares are unsigned, per ALU semantics.

Optional Feature:
- Macro: ALU_EXEC_STATS_EN.
- When defined:
  - Adds outputs stat_ops (16-bit) and stat_taken (16-bit).
  - stat_ops increments on each response handshake with rsp_illegal=0.
  - stat_taken increments on each handshake with rsp_taken=1.
  - Both wrap at 0xFFFF->0 and are cleared by rst_n.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - ALU opcode constants (ADD..SUBSF, 3-bit).
  - req_func encodings (4-bit).
  - FSM state encoding.
  - Default W=24.
- One natural sub-module: alu_func_decode. Combinational; maps req_func to ALU opcode, is_branch, branch polarity, flag-source select and illegal.

Test Plan:
- ADD, A=0x000005, B=0xFFFFFB, ALU_LAT=1 -> rsp_valid 2 edges after accept; rsp_result=0x000000, rsp_zero=1, rsp_taken=0.
- BEQ, A=B=0x123456, pc=0x000010, off=0xFFFFF0 -> alu_opcode=5; rsp_taken=1, rsp_target=0x000001; then BNE with the same operands -> rsp_taken=0.
- BGT, A=7, B=3 -> alu_opcode=4, rsp_taken=1; BLE with the same operands -> rsp_taken=0.
- req_func=13 -> rsp_illegal=1 one edge after accept; alu_* unchanged; rsp_result=0.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0, a new req_valid is ignored; release -> IDLE and next request accepted.
- rst_n low during WAIT with ALU_LAT=4 -> immediately all outputs 0 and IDLE; no rsp_valid after release. With ALU_EXEC_STATS_EN: counters return to 0.
